// File: rtl/vgpr_busy_table_encoder.sv
// Serialises a VGPR bitmap into lowest-first (vgpr_addr, vgpr_valid) beats for the busy-table clear port.
// Optional beat/register statistics counters are built when VGPR_ENC_STATS_EN is defined.
module vgpr_busy_table_encoder #(
    parameter int NUMBER_VGPR      = 1024,
    parameter int VGPR_ADDR_LENGTH = 10,
    parameter int MAX_NUMBER_WORDS = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUMBER_VGPR-1:0]      in_bitmap,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [VGPR_ADDR_LENGTH-1:0] out_vgpr_addr,
    output logic [MAX_NUMBER_WORDS-1:0] out_vgpr_valid,
    output logic                        out_last,
    output logic                        busy
`ifdef VGPR_ENC_STATS_EN
    ,
    output logic [15:0]                 stat_beats,
    output logic [15:0]                 stat_regs
`endif
);

    localparam int IDX_W = (NUMBER_VGPR > 1) ? $clog2(NUMBER_VGPR) : 1;
    localparam int SUM_W = VGPR_ADDR_LENGTH + 1;

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t                      state_q, state_d;
    logic [NUMBER_VGPR-1:0]      work_q;
    logic [VGPR_ADDR_LENGTH-1:0] addr_q;
    logic [MAX_NUMBER_WORDS-1:0] valid_q;
    logic                        last_q;

    logic [NUMBER_VGPR-1:0]      src;
    logic [NUMBER_VGPR-1:0]      remain;
    logic [VGPR_ADDR_LENGTH-1:0] base;
    logic [MAX_NUMBER_WORDS-1:0] beat_valid;
    logic                        beat_last;
    logic [SUM_W-1:0]            idx;
    logic                        load_beat;

    // Beat former: the first beat comes straight from in_bitmap so it is registered on the accept edge.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        src        = (state_q == IDLE) ? in_bitmap : work_q;
        base       = '0;
        remain     = src;
        beat_valid = '0;
        idx        = '0;
        for (int i = NUMBER_VGPR - 1; i >= 0; i--) begin
            if (src[i]) base = VGPR_ADDR_LENGTH'(i);
        end
        for (int k = 0; k < MAX_NUMBER_WORDS; k++) begin
            idx = {1'b0, base} + SUM_W'(k);
            if (idx >= SUM_W'(NUMBER_VGPR)) idx = idx - SUM_W'(NUMBER_VGPR);
            beat_valid[k]           = src[idx[IDX_W-1:0]];
            remain[idx[IDX_W-1:0]]  = 1'b0;
        end
        beat_last = (remain == '0);
    end

    always_comb begin
        state_d   = state_q;
        load_beat = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load_beat = 1'b1;
                    state_d   = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (last_q) state_d   = IDLE;
                    else        load_beat = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the working bitmap is a plain register, not a memory, so it is cleared by reset like any other state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            addr_q  <= '0;
            valid_q <= '0;
            last_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            if (load_beat) begin
                work_q  <= remain;
                addr_q  <= base;
                valid_q <= beat_valid;
                last_q  <= beat_last;
            end
        end
    end

    assign in_ready       = (state_q == IDLE);
    assign out_valid      = (state_q == EMIT);
    assign busy           = (state_q != IDLE);
    assign out_vgpr_addr  = addr_q;
    assign out_vgpr_valid = valid_q;
    assign out_last       = last_q;

`ifdef VGPR_ENC_STATS_EN
    logic [15:0] stat_beats_q, stat_regs_q;
    logic [16:0] regs_sum;
    logic        beat_accepted;

    assign beat_accepted = (state_q == EMIT) && out_ready;

    always_comb begin
        regs_sum = {1'b0, stat_regs_q};
        for (int k = 0; k < MAX_NUMBER_WORDS; k++) begin
            regs_sum = regs_sum + 17'(valid_q[k]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_beats_q <= '0;
            stat_regs_q  <= '0;
        end else if (beat_accepted) begin
            if (stat_beats_q != 16'hFFFF) stat_beats_q <= stat_beats_q + 16'd1;
            stat_regs_q <= regs_sum[16] ? 16'hFFFF : regs_sum[15:0];
        end
    end

    assign stat_beats = stat_beats_q;
    assign stat_regs  = stat_regs_q;
`endif

endmodule

// File: tb/tb_vgpr_busy_table_encoder.sv
// Directed bench for vgpr_busy_table_encoder: hand-computed beats, stalls, wrap, empty bitmap, random coverage, reset.
module tb_vgpr_busy_table_encoder;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [1023:0] in_bitmap;
    logic          out_valid;
    logic          out_ready;
    logic [9:0]    out_vgpr_addr;
    logic [3:0]    out_vgpr_valid;
    logic          out_last;
    logic          busy;
`ifdef VGPR_ENC_STATS_EN
    logic [15:0]   stat_beats;
    logic [15:0]   stat_regs;
`endif

    vgpr_busy_table_encoder dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_bitmap      (in_bitmap),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_vgpr_addr  (out_vgpr_addr),
        .out_vgpr_valid (out_vgpr_valid),
        .out_last       (out_last),
        .busy           (busy)
`ifdef VGPR_ENC_STATS_EN
        ,
        .stat_beats     (stat_beats),
        .stat_regs      (stat_regs)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [9:0] b_addr[$];
    logic [3:0] b_valid[$];
    logic       b_last[$];
    int         b_cyc[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Sends one bitmap and collects every accepted beat; stall holds out_ready low on the first beat.
    task automatic run(input logic [1023:0] bm, input int stall, input bit noise);
        int         cyc;
        int         guard;
        bit         done;
        bit         snapped;
        logic [9:0] h_addr;
        logic [3:0] h_valid;
        logic       h_last;
        b_addr.delete(); b_valid.delete(); b_last.delete(); b_cyc.delete();
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        in_bitmap = bm;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        if (noise) begin
            in_valid  = 1'b1;
            in_bitmap = '1;
        end
        cyc = 0; done = 1'b0; snapped = 1'b0;
        h_addr = '0; h_valid = '0; h_last = 1'b0;
        check("first_beat_valid", 32'(out_valid), 32'd1);
        check("in_ready_low", 32'(in_ready), 32'd0);
        while (!done && cyc < 2000) begin
            if (out_valid) begin
                if (stall > 0) begin
                    if (!snapped) begin
                        h_addr = out_vgpr_addr; h_valid = out_vgpr_valid; h_last = out_last;
                        snapped = 1'b1;
                    end else begin
                        check("hold_addr", 32'(out_vgpr_addr), 32'(h_addr));
                        check("hold_valid", 32'(out_vgpr_valid), 32'(h_valid));
                        check("hold_last", 32'(out_last), 32'(h_last));
                    end
                    stall--;
                    out_ready = 1'b0;
                end else begin
                    if (snapped) begin
                        check("hold_addr_acc", 32'(out_vgpr_addr), 32'(h_addr));
                        snapped = 1'b0;
                    end
                    out_ready = 1'b1;
                    b_addr.push_back(out_vgpr_addr);
                    b_valid.push_back(out_vgpr_valid);
                    b_last.push_back(out_last);
                    b_cyc.push_back(cyc);
                    if (out_last) done = 1'b1;
                end
            end else begin
                out_ready = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("run_done", 32'(done), 32'd1);
        check("in_ready_after", 32'(in_ready), 32'd1);
    endtask

    task automatic check_beat(input string tag, input int n, input logic [9:0] a,
                              input logic [3:0] v, input logic l);
        if (n < b_addr.size()) begin
            check({tag, "_addr"}, 32'(b_addr[n]), 32'(a));
            check({tag, "_valid"}, 32'(b_valid[n]), 32'(v));
            check({tag, "_last"}, 32'(b_last[n]), 32'(l));
        end else begin
            check({tag, "_present"}, 32'(b_addr.size()), 32'(n + 1));
        end
    endtask

    logic [1023:0] bm;
    logic [1023:0] acc;
    bit            dup;
    bit            bad_lead;
    int            lasts;

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_bitmap = '0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_addr", 32'(out_vgpr_addr), 32'd0);
        check("rst_valid", 32'(out_vgpr_valid), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        bm = '0; bm[5] = 1'b1;
        run(bm, 0, 1'b0);
        check("bit5_count", 32'(b_addr.size()), 32'd1);
        check_beat("bit5", 0, 10'd5, 4'b0001, 1'b1);

        bm = '0; bm[1023:1020] = 4'hF;
        run(bm, 0, 1'b0);
        check("top4_count", 32'(b_addr.size()), 32'd1);
        check_beat("top4", 0, 10'd1020, 4'b1111, 1'b1);

        bm = '0; bm[0] = 1'b1; bm[2] = 1'b1; bm[3] = 1'b1; bm[8] = 1'b1;
        run(bm, 0, 1'b1);
        check("gap_count", 32'(b_addr.size()), 32'd2);
        check_beat("gap_b1", 0, 10'd0, 4'b1101, 1'b0);
        check_beat("gap_b2", 1, 10'd8, 4'b0001, 1'b1);
        if (b_cyc.size() == 2) check("gap_b2_cycle", 32'(b_cyc[1]), 32'd1);

        run(bm, 3, 1'b0);
        check("stall_count", 32'(b_addr.size()), 32'd2);
        check_beat("stall_b1", 0, 10'd0, 4'b1101, 1'b0);
        check_beat("stall_b2", 1, 10'd8, 4'b0001, 1'b1);
        if (b_cyc.size() == 2) begin
            check("stall_b1_cycle", 32'(b_cyc[0]), 32'd3);
            check("stall_b2_cycle", 32'(b_cyc[1]), 32'd4);
        end

        bm = '0; bm[0] = 1'b1; bm[1023] = 1'b1;
        run(bm, 0, 1'b0);
        check("wrap_count", 32'(b_addr.size()), 32'd2);
        check_beat("wrap_b1", 0, 10'd0, 4'b0001, 1'b0);
        check_beat("wrap_b2", 1, 10'd1023, 4'b0001, 1'b1);

        bm = '0;
        run(bm, 0, 1'b0);
        check("empty_count", 32'(b_addr.size()), 32'd1);
        check_beat("empty", 0, 10'd0, 4'b0000, 1'b1);

        for (int r = 0; r < 3; r++) begin
            for (int w = 0; w < 32; w++) begin
                bm[w*32 +: 32] = (r == 1) ? ($urandom() & $urandom() & $urandom()) : $urandom();
            end
            run(bm, 0, 1'b0);
            acc = '0; dup = 1'b0; bad_lead = 1'b0; lasts = 0;
            for (int n = 0; n < b_addr.size(); n++) begin
                if (!b_valid[n][0]) bad_lead = 1'b1;
                if (b_last[n]) lasts++;
                for (int k = 0; k < 4; k++) begin
                    if (b_valid[n][k]) begin
                        if (acc[(int'(b_addr[n]) + k) % 1024]) dup = 1'b1;
                        acc[(int'(b_addr[n]) + k) % 1024] = 1'b1;
                    end
                end
            end
            check("rand_or", 32'(acc == bm), 32'd1);
            check("rand_dup", 32'(dup), 32'd0);
            check("rand_lead", 32'(bad_lead), 32'd0);
            check("rand_lasts", 32'(lasts), 32'd1);
        end

        bm = '0; bm[0] = 1'b1; bm[10] = 1'b1; bm[20] = 1'b1;
        in_bitmap = bm; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        check("mid_b1_addr", 32'(out_vgpr_addr), 32'd0);
        @(negedge clk);
        check("mid_b2_addr", 32'(out_vgpr_addr), 32'd10);
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_addr", 32'(out_vgpr_addr), 32'd0);
        check("mid_rst_valid", 32'(out_vgpr_valid), 32'd0);
        check("mid_rst_last", 32'(out_last), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
`ifdef VGPR_ENC_STATS_EN
        check("stat_beats_rst", 32'(stat_beats), 32'd0);
        check("stat_regs_rst", 32'(stat_regs), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        bm = '0; bm[100] = 1'b1; bm[101] = 1'b1;
        run(bm, 0, 1'b0);
        check("post_rst_count", 32'(b_addr.size()), 32'd1);
        check_beat("post_rst", 0, 10'd100, 4'b0011, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
